// File: rtl/pipeline_pkg.sv
// Shared front-end pipeline definitions: instruction/word sizing, prefetch
// buffer state encoding and a consume-length validity helper.
package pipeline_pkg;

  localparam int unsigned INSTR_MAX_BYTES = 5;
  localparam int unsigned WORD_BYTES      = 4;
  localparam int unsigned WORD_W          = 8 * WORD_BYTES;

  typedef logic [WORD_W-1:0]            word_t;
  typedef logic [8*INSTR_MAX_BYTES-1:0] instr_t;

  // Prefetch buffer states (legacy-compatible encoding)
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  // A consume length is meaningful only in 1..INSTR_MAX_BYTES
  function automatic logic len_ok(input logic [2:0] len);
    return (len != 3'd0) && (len <= 3'(INSTR_MAX_BYTES));
  endfunction

endpackage

// File: rtl/instr_prefetch_buffer_if.sv
// Prefetch buffer bus bundle.
//   memory side : mem_req_valid/addr/ready (request), mem_rsp_valid/data (in-order response)
//   fetch side  : out_valid/instr/pc (head of queue), consume/consume_len,
//                 redirect/redirect_pc (taken jump), halt (stop new requests)
// master = prefetch buffer, slave = memory + fetch/execute environment.
interface instr_prefetch_buffer_if;
  import pipeline_pkg::*;

  logic       mem_req_valid;
  word_t      mem_req_addr;
  logic       mem_req_ready;
  logic       mem_rsp_valid;
  word_t      mem_rsp_data;
  logic       out_valid;
  instr_t     out_instr;
  word_t      out_pc;
  logic       consume;
  logic [2:0] consume_len;
  logic       redirect;
  word_t      redirect_pc;
  logic       halt;

  modport master (
    output mem_req_valid, mem_req_addr, out_valid, out_instr, out_pc,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
           consume, consume_len, redirect, redirect_pc, halt
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, out_valid, out_instr, out_pc,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
           consume, consume_len, redirect, redirect_pc, halt
  );
endinterface

// File: rtl/instr_prefetch_buffer_byte_fifo.sv
// byte_fifo: circular byte storage for the prefetch buffer.
//   clk, rst        : clock, async active-low reset (pointers only)
//   clr_i           : empty the queue; read pointer restarts at clr_skip_i so
//                     the leading bytes of the next pushed word are skipped
//   push_i/data     : append one little-endian word (4 bytes)
//   pop_i/pop_len_i : advance head by 1..5 bytes
//   peek_o          : 5 bytes starting at head, head byte in [7:0]
// Occupancy is tracked by the parent; pointers wrap modulo DEPTH_BYTES.
module byte_fifo
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 16,
  parameter logic [1:0]  RESET_SKIP  = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic [1:0] clr_skip_i,
  input  logic       push_i,
  input  word_t      push_data_i,
  input  logic       pop_i,
  input  logic [2:0] pop_len_i,
  output instr_t     peek_o
);

  localparam int unsigned PW = $clog2(DEPTH_BYTES);

  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [7:0]    mem_q [DEPTH_BYTES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= PW'(RESET_SKIP);
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= PW'(clr_skip_i);
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(WORD_BYTES);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(pop_len_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clr_i) begin
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
        mem_q[wr_ptr_q + PW'(i)] <= push_data_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    peek_o = '0;
    for (int unsigned i = 0; i < INSTR_MAX_BYTES; i++) begin
      peek_o[8*i +: 8] = mem_q[rd_ptr_q + PW'(i)];
    end
  end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: fetches aligned words from instruction memory into a
// byte queue and presents the next 5 bytes to the decoder.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : instr_prefetch_buffer_if.master (memory request/response,
//          out_valid/out_instr/out_pc, consume, redirect, halt)
// A redirect empties the queue; requests already in flight at that point are
// counted as stale and their responses are dropped in FLUSH.
module instr_prefetch_buffer
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES     = 16,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input logic clk,
  input logic rst,
  instr_prefetch_buffer_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH_BYTES) + 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] stale_q, stale_d;
  logic          req_valid_q, req_valid_d;
  word_t         req_addr_q, req_addr_d;
  word_t         out_pc_q, out_pc_d;
  logic [1:0]    drop_q, drop_d;

  logic   out_valid;
  logic   acc, rsp_take, push, pop;
  instr_t peek;

  assign out_valid = (count_q >= CW'(INSTR_MAX_BYTES));
  assign acc       = req_valid_q && bus.mem_req_ready;
  // Responses with nothing in flight (e.g. left over from before reset) are ignored
  assign rsp_take  = bus.mem_rsp_valid && (outst_q != '0);
  assign push      = rsp_take && (state_q == ST_RUN) && (stale_q == '0) && !bus.redirect;
  assign pop       = bus.consume && out_valid && len_ok(bus.consume_len) && !bus.redirect;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    outst_d     = outst_q + OW'(acc) - OW'(rsp_take);
    stale_d     = stale_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    out_pc_d    = out_pc_q;
    drop_d      = drop_q;

    if (bus.redirect) begin
      // Everything still in flight after this cycle belongs to the old stream
      count_d     = '0;
      out_pc_d    = bus.redirect_pc;
      drop_d      = bus.redirect_pc[1:0];
      stale_d     = outst_d;
      state_d     = (outst_d != '0) ? ST_FLUSH : ST_RUN;
      req_addr_d  = {bus.redirect_pc[31:2], 2'b00};
      req_valid_d = 1'b0;
    end else begin
      if (pop) begin
        count_d  = count_d - CW'(bus.consume_len);
        out_pc_d = out_pc_q + 32'(bus.consume_len);
      end
      if (push) begin
        // First word after a redirect contributes only the bytes at/after the target
        count_d = count_d + CW'(3'd4 - {1'b0, drop_q});
        drop_d  = 2'b00;
      end
      if ((state_q == ST_FLUSH) && rsp_take) begin
        stale_d = stale_q - OW'(1);
        if (stale_d == '0) state_d = ST_RUN;
      end
      if (acc) req_addr_d = req_addr_q + 32'd4;

      if (req_valid_q && !bus.mem_req_ready) begin
        req_valid_d = 1'b1;
      end else begin
        // Reserve queue space for every in-flight word plus the new one
        req_valid_d = (state_d == ST_RUN) && !bus.halt &&
                      (32'(outst_d) < MAX_OUTSTANDING) &&
                      ((32'(count_d) + 32'd4 * (32'(outst_d) + 32'd1)) <= DEPTH_BYTES);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      count_q     <= '0;
      outst_q     <= '0;
      stale_q     <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= {RESET_PC[31:2], 2'b00};
      out_pc_q    <= RESET_PC;
      drop_q      <= RESET_PC[1:0];
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      outst_q     <= outst_d;
      stale_q     <= stale_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      out_pc_q    <= out_pc_d;
      drop_q      <= drop_d;
    end
  end

  byte_fifo #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .RESET_SKIP  (RESET_PC[1:0])
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (bus.redirect),
    .clr_skip_i  (bus.redirect_pc[1:0]),
    .push_i      (push),
    .push_data_i (bus.mem_rsp_data),
    .pop_i       (pop),
    .pop_len_i   (bus.consume_len),
    .peek_o      (peek)
  );

  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.out_valid     = out_valid;
  assign bus.out_instr     = out_valid ? peek : '0;
  assign bus.out_pc        = out_pc_q;

endmodule

// File: doc/instr_prefetch_buffer.md
INSTR_PREFETCH_BUFFER -- requirements
Module: instr_prefetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 16; byte-queue capacity (power of two, at least 8).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2; maximum in-flight memory reads.
REQ-003 SHALL have parameter RESET_PC, default 32'h0; first fetch address after reset.
REQ-004 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit; asynchronous, active-low reset.
REQ-006 SHALL have port mem_req_valid, output, 1 bit; read request to instruction memory.
REQ-007 SHALL have port mem_req_addr, output, 32 bits; word-aligned read address, bits [1:0] always 0.
REQ-008 SHALL have port mem_req_ready, input, 1 bit; memory accepts the request.
REQ-009 SHALL have port mem_rsp_valid, input, 1 bit; read data returned, in request order.
REQ-010 SHALL have port mem_rsp_data, input, 32 bits; little-endian word, byte at the lowest address in bits [7:0].
REQ-011 SHALL have port out_valid, output, 1 bit; at least 5 bytes are queued.
REQ-012 SHALL have port out_instr, output, 40 bits; next 5 queued bytes, byte at out_pc in bits [7:0].
REQ-013 SHALL have port out_pc, output, 32 bits; address of out_instr[7:0].
REQ-014 SHALL have port consume, input, 1 bit; the fetch stage takes one instruction.
REQ-015 SHALL have port consume_len, input, 3 bits; length of the taken instruction, 1 to 5 bytes.
REQ-016 SHALL have port redirect, input, 1 bit; taken jump from execute.
REQ-017 SHALL have port redirect_pc, input, 32 bits; jump target.
REQ-018 SHALL have port halt, input, 1 bit; stop issuing new memory requests.

Function
REQ-019 SHALL issue a request only when count + 4*(outstanding+1) <= DEPTH_BYTES, outstanding < MAX_OUTSTANDING, halt=0, and the state is RUN.
REQ-020 SHALL hold mem_req_valid and mem_req_addr stable until mem_req_ready; the transfer occurs when valid and ready are both 1, after which the next address is addr+4.
REQ-021 SHALL append each non-stale response's 4 bytes to the queue in the same cycle it arrives; count +4.
REQ-022 SHALL drop the leading redirect_pc[1:0] bytes of the first response after a redirect; out_pc then equals redirect_pc.
REQ-023 SHALL, on consume with out_valid=1, advance the queue head and out_pc by consume_len; count -consume_len.
REQ-024 SHALL ignore consume when out_valid=0, or when consume_len is 0 or greater than 5.
REQ-025 SHALL, when consume and a response occur in the same cycle, set count to count - consume_len + 4.
REQ-026 SHALL have states RUN and FLUSH.
REQ-027 SHALL, in any state on redirect, clear the queue, set out_pc=redirect_pc, set stale_cnt to outstanding plus any request being accepted that cycle, and drop mem_req_valid the next cycle.
REQ-028 SHALL go from RUN to FLUSH on redirect when stale_cnt > 0; otherwise it SHALL remain in RUN and fetch from {redirect_pc[31:2],2'b00}.
REQ-029 SHALL, in FLUSH, discard responses and decrement stale_cnt, with no requests issued; when stale_cnt reaches 0 it SHALL return to RUN.
REQ-030 SHALL give redirect priority over a simultaneous consume or response; a response in that cycle counts as stale.
REQ-031 SHALL, while halt=1, keep delivering queued bytes and still accept outstanding responses.

Reset
REQ-032 SHALL, on rst=0, asynchronously set state=RUN, count=0, outstanding=0, stale_cnt=0, mem_req_valid=0, mem_req_addr=RESET_PC, out_valid=0, out_pc=RESET_PC and out_instr=0.
REQ-033 SHALL discard any responses that arrive during reset or mid-transaction reset; the first request after reset SHALL come in the first cycle after rst rises.

Structure
REQ-034 SHALL take INSTR_MAX_BYTES=5, the word width and the state encoding from the shared package pipeline_pkg.
REQ-035 SHALL place the circular byte storage in one sub-module, byte_fifo, which has a 4-byte push, a variable 1-5 byte pop, and a 5-byte peek; pointers wrap modulo DEPTH_BYTES.

Verification
REQ-036 SHALL test reset then memory returning 0x03020100, 0x07060504 -> out_valid=1, out_instr=40'h0403020100, out_pc=0.
REQ-037 SHALL test consume_len=3 then 2 -> out_pc=3 then 5; the bytes are correct across the word boundary and the pointer wraps at 16.
REQ-038 SHALL test redirect to 0x102 with 2 requests outstanding -> 2 responses discarded, next request to 0x100, out_pc=0x102, out_instr[7:0] equal to the byte at 0x102.
REQ-039 SHALL test mem_req_ready held at 0 for 5 cycles -> mem_req_valid and mem_req_addr stay stable, with no duplicate request.
REQ-040 SHALL test a full queue (count=16) with no consume -> mem_req_valid=0; one consume of 4 -> one new request.
REQ-041 SHALL test a redirect in the same cycle as consume and a response -> queue empty next cycle, and that response discarded.
